// File: rtl/water_led_pkg.sv
// Shared constants for the running-light generator family.
// Pattern select codes and bounce direction encodings.
package water_led_pkg;

   localparam logic [1:0] MODE_SHL    = 2'd0;
   localparam logic [1:0] MODE_SHR    = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;
   localparam logic [1:0] MODE_BAR    = 2'd3;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_prescaler.sv
// Step-rate generator: base prescaler plus 2^speed divider, gated by run.
// adv_free is combinational and fires on the last cycle of a step period.
module led_prescaler #(
   parameter int COUNT_WIDTH = 26,
   parameter int COUNT_MAX   = 49_999_999
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       clear,
   input  logic [1:0] speed,
   output logic       adv_free
);

   localparam logic [COUNT_WIDTH-1:0] CNT_TOP = COUNT_WIDTH'(COUNT_MAX);

   logic [COUNT_WIDTH-1:0] cnt;
   logic [2:0]             spd_cnt;
   logic [2:0]             spd_lim;
   logic                   base_tick;
   logic                   spd_hit;

   always_comb begin
      spd_lim   = 3'((4'b0001 << speed) - 4'b0001);
      base_tick = run && (cnt == CNT_TOP);
      // >= rather than == so a speed decrease mid-count fires on the next base tick
      spd_hit   = (spd_cnt >= spd_lim);
      adv_free  = base_tick && spd_hit && !clear;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         spd_cnt <= '0;
      end else if (clear || !run) begin
         cnt     <= '0;
         spd_cnt <= '0;
      end else if (base_tick) begin
         cnt     <= '0;
         spd_cnt <= spd_hit ? 3'd0 : spd_cnt + 3'd1;
      end else begin
         cnt     <= cnt + COUNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/water_led_multi.sv
// Multi-mode running-light generator: SHL, SHR, BOUNCE and BAR patterns on an LED bank.
// Pattern register updates one edge after an advance decision; tick marks each update.
module water_led_multi
   import water_led_pkg::*;
#(
   parameter int LED_NUM     = 8,
   parameter int COUNT_WIDTH = 26,
   parameter int COUNT_MAX   = 49_999_999,
   parameter bit ACTIVE_LOW  = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         mode,
   input  logic [1:0]         speed,
   input  logic               run,
   input  logic               step,
   output logic [LED_NUM-1:0] led,
   output logic               tick
);

   logic [LED_NUM-1:0] pat;
   logic [LED_NUM-1:0] pat_nxt;
   logic               dir;
   logic               dir_nxt;
   logic [1:0]         mode_q;
   logic               step_d;
   logic               reload;
   logic               adv_free;
   logic               adv;

   function automatic logic [LED_NUM-1:0] init_pat(input logic [1:0] m);
      case (m)
         MODE_SHR: return {1'b1, {(LED_NUM-1){1'b0}}};
         MODE_BAR: return '0;
         default:  return LED_NUM'(1);
      endcase
   endfunction

   led_prescaler #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .COUNT_MAX   (COUNT_MAX)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .clear    (reload),
      .speed    (speed),
      .adv_free (adv_free)
   );

   // A reload swallows any coincident advance so tick stays low on that edge.
   always_comb begin
      reload = (mode != mode_q);
      if (reload)
         adv = 1'b0;
      else if (run)
         adv = adv_free;
      else
         adv = step && !step_d;
   end

   always_comb begin
      pat_nxt = pat;
      dir_nxt = dir;
      case (mode_q)
         MODE_SHL: pat_nxt = {pat[LED_NUM-2:0], pat[LED_NUM-1]};
         MODE_SHR: pat_nxt = {pat[0], pat[LED_NUM-1:1]};
         MODE_BOUNCE: begin
            if (dir == DIR_UP) begin
               if (pat[LED_NUM-1]) begin
                  dir_nxt = DIR_DOWN;
                  pat_nxt = pat >> 1;
               end else begin
                  pat_nxt = pat << 1;
               end
            end else begin
               if (pat[0]) begin
                  dir_nxt = DIR_UP;
                  pat_nxt = pat << 1;
               end else begin
                  pat_nxt = pat >> 1;
               end
            end
         end
         default: pat_nxt = {pat[LED_NUM-2:0], ~pat[LED_NUM-1]};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat    <= LED_NUM'(1);
         dir    <= DIR_UP;
         mode_q <= MODE_SHL;
         step_d <= 1'b0;
         tick   <= 1'b0;
      end else begin
         step_d <= step;
         tick   <= adv;
         if (reload) begin
            pat    <= init_pat(mode);
            dir    <= DIR_UP;
            mode_q <= mode;
         end else if (adv) begin
            pat    <= pat_nxt;
            dir    <= dir_nxt;
         end
      end
   end

   assign led = ACTIVE_LOW ? ~pat : pat;

endmodule

// File: tb/tb_water_led_multi.sv
// Randomized bench for water_led_multi against a position-index reference model.
module tb_water_led_multi;

   localparam int N  = 6;
   localparam int CW = 2;
   localparam int CM = 2;

   logic         clk;
   logic         rst_n;
   logic [1:0]   mode;
   logic [1:0]   speed;
   logic         run;
   logic         step;
   logic [N-1:0] led;
   logic [N-1:0] led_al;
   logic         tick;
   logic         tick_al;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state: mode in force, advances since reload, cycle phase, base ticks
   int m_mode, m_k, m_phase, m_bt;
   bit m_step_prev, m_tick;

   water_led_multi #(.LED_NUM(N), .COUNT_WIDTH(CW), .COUNT_MAX(CM), .ACTIVE_LOW(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .speed(speed), .run(run), .step(step),
      .led(led), .tick(tick)
   );

   water_led_multi #(.LED_NUM(N), .COUNT_WIDTH(CW), .COUNT_MAX(CM), .ACTIVE_LOW(1'b1)) u_dut_al (
      .clk(clk), .rst_n(rst_n), .mode(mode), .speed(speed), .run(run), .step(step),
      .led(led_al), .tick(tick_al)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // k-th pattern of a sequence computed from its position, not from the previous pattern
   function automatic logic [N-1:0] ref_pat(input int m, input int k);
      int p;
      int pos;
      case (m)
         0: return N'(1 << (k % N));
         1: return N'(1 << (N - 1 - (k % N)));
         2: begin
            p   = k % (2*N - 2);
            pos = (p < N) ? p : (2*N - 2 - p);
            return N'(1 << pos);
         end
         default: begin
            p = k % (2*N);
            if (p <= N) return N'((1 << p) - 1);
            return N'(((1 << N) - 1) & ~((1 << (p - N)) - 1));
         end
      endcase
   endfunction

   task automatic model_reset();
      m_mode = 0; m_k = 0; m_phase = 0; m_bt = 0;
      m_step_prev = 1'b0; m_tick = 1'b0;
   endtask

   task automatic model_edge();
      bit adv;
      adv    = 1'b0;
      m_tick = 1'b0;
      if (int'(mode) != m_mode) begin
         m_mode = int'(mode); m_k = 0; m_phase = 0; m_bt = 0;
      end else begin
         if (run) begin
            if (m_phase == CM) begin
               m_phase = 0;
               m_bt++;
               if (m_bt >= (1 << speed)) begin
                  adv  = 1'b1;
                  m_bt = 0;
               end
            end else begin
               m_phase++;
            end
         end else begin
            m_phase = 0; m_bt = 0;
            adv = step && !m_step_prev;
         end
         if (adv) begin
            m_k++;
            m_tick = 1'b1;
         end
      end
      m_step_prev = step;
   endtask

   task automatic check_all();
      logic [N-1:0] e;
      logic [N-1:0] e_inv;
      e     = ref_pat(m_mode, m_k);
      e_inv = ~e;
      chk("led", 32'(led), 32'(e));
      chk("led_al", 32'(led_al), 32'(e_inv));
      chk("tick", 32'(tick), 32'(m_tick));
      chk("tick_al", 32'(tick_al), 32'(m_tick));
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // called at a negedge; assert mid-cycle, check asynchronously, release at the next negedge
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; mode = 2'd0; speed = 2'd0; run = 1'b1; step = 1'b0;
      model_reset();
      @(negedge clk);
      chk("rst_led", 32'(led), 32'h01);
      chk("rst_led_al", 32'(led_al), 32'h3e);
      chk("rst_tick", 32'(tick), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      cycles(2);
      chk("pre_first_adv", 32'(led), 32'h01);
      cyc();
      chk("first_adv", 32'(led), 32'h02);
      chk("first_tick", 32'(tick), 32'h1);
      cycles(20);

      mode = 2'd2; cycles(40);
      mode = 2'd3; cycles(45);

      mode = 2'd0; speed = 2'd2; cycles(31);
      speed = 2'd0; cycles(10);

      run = 1'b0; cycles(8);
      step = 1'b1; cyc(); step = 1'b0; cycles(4);
      step = 1'b1; cycles(5); step = 1'b0; cycles(3);
      run = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step = ~step;
         cyc();
      end
      step = 1'b0;

      // run to 000100 in SHL, then switch to SHR
      mode = 2'd0; speed = 2'd0; cycles(2);
      for (int i = 0; i < 40 && led != 6'b000100; i++) cyc();
      chk("reach_000100", 32'(led), 32'h04);
      mode = 2'd1; cyc();
      chk("reload_led", 32'(led), 32'h20);
      chk("reload_tick", 32'(tick), 32'h0);
      cycles(2);
      chk("reload_hold", 32'(led), 32'h20);
      cyc();
      chk("reload_next", 32'(led), 32'h10);
      chk("reload_next_tick", 32'(tick), 32'h1);

      // step already high when reset releases with run=0
      run = 1'b0; step = 1'b1; mode = 2'd0;
      do_reset();
      cycles(4);
      step = 1'b0; run = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(15) == 0) mode  = 2'($urandom_range(3));
         if ($urandom_range(15) == 0) speed = 2'($urandom_range(3));
         if ($urandom_range(20) == 0) run   = ~run;
         if ($urandom_range(3) == 0)  step  = ~step;
         if ($urandom_range(250) == 0) do_reset();
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/water_led_multi.md
# water_led_multi

Parametrised multi-mode running-light generator, the successor to the fixed-pattern water LED block. It drives an LED_NUM-wide LED bank with one of four runtime-selectable patterns. The step rate is a prescaled tick with a runtime speed divider. A run/pause control and a single-step input support debug, and a tick strobe marks every pattern update. It sits directly between the board clock/reset and the LED pins.

## Interface
- LED_NUM, 8: LED count, ≥2.
- COUNT_WIDTH, 26: prescaler counter width; COUNT_MAX must be < 2^COUNT_WIDTH.
- COUNT_MAX, 49_999_999: prescaler terminal value; base period is COUNT_MAX+1 cycles.
- ACTIVE_LOW, 0: 1 inverts all `led` outputs.
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  2  pattern select: 0 SHL, 1 SHR, 2 BOUNCE, 3 BAR.
- speed  in  2  rate divider: an advance occurs every 2^speed base ticks.
- run  in  1  1 = free-run; 0 = pause, with stepping allowed.
- step  in  1  single-step request; only its rising edge is used, and only while run=0.
- led  out  LED_NUM  pattern output; equals pat, or ~pat when ACTIVE_LOW=1.
- tick  out  1  one-cycle strobe, high in the cycle a new pattern first appears on `led`.

## Operation
- State: pat[LED_NUM-1:0], dir (BOUNCE only), mode_q, cnt[COUNT_WIDTH-1:0], spd_cnt[2:0], step_d.
- Reset values:
  - pat=1 and mode_q=0.
  - dir=up.
  - cnt=0, spd_cnt=0 and step_d=0.
  - tick=0.
  - Resulting `led` is 1, or ~1 when ACTIVE_LOW=1.
- Prescaler (run=1):
  - cnt counts 0..COUNT_MAX and wraps to 0.
  - base_tick is asserted when cnt==COUNT_MAX.
  - On each base_tick: if spd_cnt ≥ 2^speed−1, then adv=1 and spd_cnt←0; otherwise spd_cnt increments.
  - The ≥ compare guarantees that a speed decrease mid-count fires on the next base_tick.
- Pause (run=0):
  - cnt and spd_cnt are held at 0.
  - adv = step & ~step_d.
  - step_d samples step every cycle, regardless of run.
- Mode reload:
  - Triggered when mode≠mode_q, regardless of run.
  - pat←init(mode) and dir←up.
  - cnt←0 and spd_cnt←0.
  - mode_q←mode.
  - Reload has priority over adv; tick stays 0 in that cycle.
- Advance rules, N=LED_NUM:
  - SHL: init 1; rotate left (bit N−1 → bit 0). Period N.
  - SHR: init 1<<(N−1); rotate right. Period N.
  - BOUNCE: init 1, dir=up.
    - Up: if pat[N−1], then dir←down and pat←pat>>1; otherwise pat←pat<<1.
    - Down: if pat[0], then dir←up and pat←pat<<1; otherwise pat←pat>>1.
    - Period 2N−2; end LEDs are lit once per sweep.
  - BAR: init 0; Johnson shift pat←{pat[N−2:0], ~pat[N−1]}. Fills, then empties from the LSB side. Period 2N.
- tick is registered from adv, so it rises on the same edge that updates pat.

## Timing
- Free-run advance period: (COUNT_MAX+1)·2^speed cycles.
- First advance: COUNT_MAX+1 edges after the first edge with rst_n=1 and run=1, at speed=0.
- Clearing run discards the partial count. Setting run again starts a full period.
- Step latency: pat updates on the first edge that samples step=1 after a 0. Holding step high produces exactly one advance.
- Step is ignored while run=1.
- If step is already high at reset release with run=0, it counts as one rising edge, because step_d resets to 0.
- Mode change latency: 1 edge. The next advance comes a full period after the reload.
- Speed change: takes effect without reload; pat and cnt are not disturbed.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). If mode≠0 at release, reload occurs on the first edge.

## Structure
- Shared package water_led_pkg holds:
  - MODE_SHL=2'd0, MODE_SHR=2'd1, MODE_BOUNCE=2'd2, MODE_BAR=2'd3;
  - the DIR_UP/DIR_DOWN constants.
- Sub-module led_prescaler:
  - contains cnt, spd_cnt, the run gating and the clear input;
  - parameters COUNT_WIDTH and COUNT_MAX;
  - outputs the adv_free strobe.
- Top level contains pat/dir, mode reload, step edge detect, output inversion and tick.

## Test plan
All scenarios use LED_NUM=6, COUNT_WIDTH=2, COUNT_MAX=2.
- Reset, then mode=0, run=1, speed=0:
  - led=000001 during reset, then 000010 three cycles after release;
  - continues …100000→000001 wrap;
  - tick pulses every 3 cycles, coincident with each change.
- mode=2, then mode=3, each with run=1:
  - BOUNCE: 000001, 000010 … 100000, 010000 … 000001, repeating every 10 advances.
  - BAR: 000000, 000001, 000011 … 111111, 111110 … 100000, 000000, repeating every 12.
- speed=2: advances every 12 cycles. Switch to speed=0 mid-count: the next advance occurs at the next base_tick, and pat is unchanged by the switch.
- run=0:
  - led is frozen and tick stays 0;
  - a 1-cycle step gives exactly one advance;
  - step held high for 5 cycles gives one advance;
  - step pulsed while run=1 gives no extra advance.
- Mode change from 0 to 1 while running at led=000100:
  - next edge gives led=100000 with tick=0;
  - the next advance comes exactly 3 cycles later.
- ACTIVE_LOW=1: led=111110 during reset, and every subsequent value is the bitwise inverse of the ACTIVE_LOW=0 run.
